// File: rtl/des_round_engine_pkg.sv
// DES constants, permutation and S-box tables, FSM state type and bit-level helpers.
// Table entries use 1-based DES numbering; DES bit n of a w-bit word sits at index w-n.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each S-box is stored row-major: entry = row*16 + column.
    localparam logic [3:0] SBOX_T [8][64] = '{
        '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
          4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
          4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
          4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
        '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
          4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
          4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
          4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
        '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
          4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
          4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
        '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
          4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
          4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
          4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
        '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
          4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
          4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
          4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
        '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
          4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
          4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
          4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
        '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
          4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
          4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
          4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
        '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
          4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
          4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
          4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] d);
        logic [63:0] o;
        for (int j = 0; j < 64; j++) o[6'(63 - j)] = d[6'(64 - IP_T[j])];
        return o;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] d);
        logic [63:0] o;
        for (int j = 0; j < 64; j++) o[6'(63 - j)] = d[6'(64 - FP_T[j])];
        return o;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] o;
        for (int j = 0; j < 48; j++) o[6'(47 - j)] = r[5'(32 - E_T[j])];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] d);
        logic [31:0] o;
        for (int j = 0; j < 32; j++) o[5'(31 - j)] = d[5'(32 - P_T[j])];
        return o;
    endfunction

    // Row comes from the outer two bits, column from the inner four.
    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
        return SBOX_T[n][{b[5], b[0], b[4:1]}];
    endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Block handshake between the DES round engine and its upstream/downstream controller.
interface des_round_engine_if;
    import des_pkg::*;

    logic               start;
    logic               decrypt;
    logic [BLOCK_W-1:0] data_in;
    logic [BLOCK_W-1:0] data_out;
    logic               busy;
    logic               done;

    modport master (output start, decrypt, data_in, input data_out, busy, done);
    modport slave  (input start, decrypt, data_in, output data_out, busy, done);
endinterface

// File: rtl/des_round_engine_f_func.sv
// DES Feistel function f(R,K): expand, key mix, S-box substitution, P permutation.
module des_f_func
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r,
    input  logic [SUBKEY_W-1:0] k,
    output logic [HALF_W-1:0]   f_out
);

    logic [SUBKEY_W-1:0] x;
    logic [HALF_W-1:0]   s_out;

    always_comb begin
        x     = e_expand(r) ^ k;
        s_out = '0;
        // S1 consumes the most significant six bits and yields the top nibble.
        for (int i = 0; i < 8; i++) begin
            s_out[4*(7-i) +: 4] = sbox(3'(i), x[6*(7-i) +: 6]);
        end
        f_out = p_perm(s_out);
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: one Feistel round per clock, start/busy/done handshake.
// Build option DES_KEY_LATCH_EN: capture all 16 subkeys when a block is accepted.
module des_round_engine
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    des_round_engine_if.slave   bus,
    input  logic [SUBKEY_W-1:0] key1,
    input  logic [SUBKEY_W-1:0] key2,
    input  logic [SUBKEY_W-1:0] key3,
    input  logic [SUBKEY_W-1:0] key4,
    input  logic [SUBKEY_W-1:0] key5,
    input  logic [SUBKEY_W-1:0] key6,
    input  logic [SUBKEY_W-1:0] key7,
    input  logic [SUBKEY_W-1:0] key8,
    input  logic [SUBKEY_W-1:0] key9,
    input  logic [SUBKEY_W-1:0] key10,
    input  logic [SUBKEY_W-1:0] key11,
    input  logic [SUBKEY_W-1:0] key12,
    input  logic [SUBKEY_W-1:0] key13,
    input  logic [SUBKEY_W-1:0] key14,
    input  logic [SUBKEY_W-1:0] key15,
    input  logic [SUBKEY_W-1:0] key16
);

    state_t              state;
    logic [4:0]          cnt;
    logic                dec_q;
    logic [HALF_W-1:0]   l_q;
    logic [HALF_W-1:0]   r_q;
    logic [BLOCK_W-1:0]  data_out_q;
    logic                busy_q;
    logic                done_q;

    logic [SUBKEY_W-1:0] key_live [ROUNDS];
    logic [3:0]          key_idx;
    logic [SUBKEY_W-1:0] round_key;
    logic [HALF_W-1:0]   f_val;
    logic [BLOCK_W-1:0]  ip_in;

    assign key_live[0]  = key1;
    assign key_live[1]  = key2;
    assign key_live[2]  = key3;
    assign key_live[3]  = key4;
    assign key_live[4]  = key5;
    assign key_live[5]  = key6;
    assign key_live[6]  = key7;
    assign key_live[7]  = key8;
    assign key_live[8]  = key9;
    assign key_live[9]  = key10;
    assign key_live[10] = key11;
    assign key_live[11] = key12;
    assign key_live[12] = key13;
    assign key_live[13] = key14;
    assign key_live[14] = key15;
    assign key_live[15] = key16;

    // cnt runs 1..16; 4-bit wraparound maps it to key n-1 (encrypt) or 16-n (decrypt).
    assign key_idx = dec_q ? (4'd0 - cnt[3:0]) : (cnt[3:0] - 4'd1);

`ifdef DES_KEY_LATCH_EN
    logic [SUBKEY_W-1:0] key_bank [ROUNDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROUNDS; i++) key_bank[i] <= '0;
        end else if (state == IDLE && bus.start) begin
            for (int i = 0; i < ROUNDS; i++) key_bank[i] <= key_live[i];
        end
    end

    assign round_key = key_bank[key_idx];
`else
    assign round_key = key_live[key_idx];
`endif

    des_f_func u_f_func (
        .r     (r_q),
        .k     (round_key),
        .f_out (f_val)
    );

    assign ip_in = ip_perm(bus.data_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dec_q      <= 1'b0;
            l_q        <= '0;
            r_q        <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dec_q  <= bus.decrypt;
                        l_q    <= ip_in[BLOCK_W-1:HALF_W];
                        r_q    <= ip_in[HALF_W-1:0];
                        cnt    <= 5'd1;
                        busy_q <= 1'b1;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    l_q <= r_q;
                    r_q <= l_q ^ f_val;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ROUNDS)) state <= FINISH;
                end
                FINISH: begin
                    // Halves are swapped after the last round before FP.
                    data_out_q <= fp_perm({r_q, l_q});
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    cnt        <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: known-answer vectors plus handshake corner cases.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] kb [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_round_engine_if bus();

    des_round_engine dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .key1  (kb[0]),  .key2  (kb[1]),  .key3  (kb[2]),  .key4  (kb[3]),
        .key5  (kb[4]),  .key6  (kb[5]),  .key7  (kb[6]),  .key8  (kb[7]),
        .key9  (kb[8]),  .key10 (kb[9]),  .key11 (kb[10]), .key12 (kb[11]),
        .key13 (kb[12]), .key14 (kb[13]), .key15 (kb[14]), .key16 (kb[15])
    );

    // Subkeys of 133457799BBCDFF1 from the DES key schedule.
    localparam logic [47:0] KS_CLASSIC [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] CTZ = 64'h8CA64DE9C1B123A7;

    typedef struct {
        logic        dec;
        logic        zero_key;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
        n_checks++;
        if (act === bad) begin
            n_fail++;
            $display("FAIL %s: got %h, expected anything else", name, act);
        end
    endtask

    task automatic set_keys(input bit zero);
        for (int i = 0; i < 16; i++) kb[i] = zero ? 48'h0 : KS_CLASSIC[i];
    endtask

    // Presents start for one edge; returns after that accepting edge with its cycle stamp.
    task automatic issue(input logic dec, input logic [63:0] din, output int t0);
        bus.start   = 1'b1;
        bus.decrypt = dec;
        bus.data_in = din;
        step();
        t0 = cyc;
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic wait_done(input int limit, output int t_done, output bit busy_gap);
        int n;
        n = 0;
        busy_gap = 1'b0;
        while (!bus.done && n < limit) begin
            if (!bus.busy) busy_gap = 1'b1;
            step();
            n++;
        end
        t_done = cyc;
    endtask

    task automatic count_dones(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        int  t0, t1, t2, td, extra;
        bit  gap;

        vecs[0] = '{dec: 1'b0, zero_key: 1'b0, din: PT,    exp: CT};
        vecs[1] = '{dec: 1'b1, zero_key: 1'b0, din: CT,    exp: PT};
        vecs[2] = '{dec: 1'b0, zero_key: 1'b1, din: 64'h0, exp: CTZ};
        vecs[3] = '{dec: 1'b1, zero_key: 1'b1, din: CTZ,   exp: 64'h0};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.data_in = '0;
        set_keys(1'b0);
        repeat (3) step();
        check("reset data_out", bus.data_out, 64'h0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            set_keys(vecs[v].zero_key);
            issue(vecs[v].dec, vecs[v].din, t0);
            wait_done(40, td, gap);
            check($sformatf("vec%0d busy window", v), 64'(gap), 64'd0);
            check($sformatf("vec%0d latency", v), 64'(td - t0), 64'd17);
            check($sformatf("vec%0d data_out", v), bus.data_out, vecs[v].exp);
            check($sformatf("vec%0d busy at done", v), 64'(bus.busy), 64'd0);
            step();
        end

        // Back-to-back: second start presented in the done cycle.
        set_keys(1'b1);
        issue(1'b0, 64'h0, t0);
        wait_done(40, t1, gap);
        check("b2b first latency", 64'(t1 - t0), 64'd17);
        check("b2b first data", bus.data_out, CTZ);
        issue(1'b1, CTZ, t2);
        check("b2b restart gap", 64'(t2 - t0), 64'd18);
        wait_done(40, td, gap);
        check("b2b second done", 64'(td - t0), 64'd35);
        check("b2b second data", bus.data_out, 64'h0);
        step();

        // Start pulsed mid-operation must be ignored.
        set_keys(1'b0);
        issue(1'b0, PT, t0);
        repeat (5) step();
        bus.start   = 1'b1;
        bus.decrypt = 1'b1;
        bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.data_in = '0;
        wait_done(40, td, gap);
        check("ignored start latency", 64'(td - t0), 64'd17);
        check("ignored start data", bus.data_out, CT);
        count_dones(25, extra);
        check("ignored start extra done", 64'(extra), 64'd0);

        // Reset mid-operation discards the block.
        issue(1'b0, PT, t0);
        repeat (7) step();
        rst = 1'b1;
        step();
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst data_out", bus.data_out, 64'h0);
        rst = 1'b0;
        count_dones(25, extra);
        check("midrst no done", 64'(extra), 64'd0);
        issue(1'b1, CT, t0);
        wait_done(40, td, gap);
        check("post-reset latency", 64'(td - t0), 64'd17);
        check("post-reset data", bus.data_out, PT);
        step();

        // Key changed after round 3.
        set_keys(1'b0);
        issue(1'b0, PT, t0);
        repeat (3) step();
        set_keys(1'b1);
        wait_done(40, td, gap);
        check("keychg latency", 64'(td - t0), 64'd17);
`ifdef DES_KEY_LATCH_EN
        check("keychg latched data", bus.data_out, CT);
`else
        check_ne("keychg live data", bus.data_out, CT);
`endif
        set_keys(1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
